// File: rtl/battleship_pkg.sv
// battleship_pkg: shared cell codes, play status codes, grid/fleet defaults, scanner states
package battleship_pkg;
  localparam logic [3:0] CELL_EMPTY = 4'd0;
  localparam logic [3:0] CELL_PREVIEW_SHIP = 4'd1;
  localparam logic [3:0] CELL_MISS = 4'd2;
  localparam logic [3:0] CELL_SHIP = 4'd4;
  localparam logic [3:0] CELL_HIT = 4'd5;
  localparam logic [3:0] CELL_PREVIEW = 4'd7;
  localparam logic [3:0] CELL_INVALID = 4'd10;
  localparam logic [1:0] PLAY_PLACEMENT = 2'd1;
  localparam logic [1:0] PLAY_TURN = 2'd2;
  localparam int DEF_GRID_N = 8;
  localparam int DEF_RD_LAT = 2;
  localparam int DEF_FLEET_CELLS = 9;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} scan_state_t;
endpackage

// File: rtl/cell_classifier.sv
// cell_classifier: maps a 4-bit cell code to {is_ship, is_hit}
//   cell_value in : cell code from the cell memory
//   is_ship   out : intact ship or placement-preview ship
//   is_hit    out : ship cell that has been hit
module cell_classifier
  import battleship_pkg::*;
(
  input  logic [3:0] cell_value,
  output logic       is_ship,
  output logic       is_hit
);
  assign is_ship = cell_value == CELL_SHIP || cell_value == CELL_PREVIEW_SHIP;
  assign is_hit = cell_value == CELL_HIT;
endmodule

// File: rtl/fleet_scanner.sv
// fleet_scanner: walks every grid cell through the memory read port and counts ship/hit cells
//   clk_in, rst           : clock, async active-high reset
//   start                 : request a full scan (honoured only in IDLE)
//   scan_x, scan_y        : cell address to the memory read port
//   cell_value            : registered read data from the memory
//   busy, done            : scan in progress, one-cycle result-update pulse
//   ship_count, hit_count : results of the last completed scan
//   fleet_complete        : ship_count + hit_count == FLEET_CELLS
//   all_sunk              : no intact ship cells but at least one hit
module fleet_scanner
  import battleship_pkg::*;
#(
  parameter int GRID_N = DEF_GRID_N,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int FLEET_CELLS = DEF_FLEET_CELLS,
  localparam int CW = $clog2(GRID_N)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          start,
  output logic [CW-1:0] scan_x,
  output logic [CW-1:0] scan_y,
  input  logic [3:0]    cell_value,
  output logic          busy,
  output logic          done,
  output logic [6:0]    ship_count,
  output logic [6:0]    hit_count,
  output logic          fleet_complete,
  output logic          all_sunk
);
  scan_state_t state;
  logic [6:0] acc_ship, acc_hit;
  logic [RD_LAT-2:0] vld;
  logic [RD_LAT-1:0] tag;
  logic is_ship, is_hit, x_last, last_addr;
  // tag[0] marks the address issued this cycle; tag[RD_LAT-1] marks the one whose data is on cell_value now
  assign tag = {vld, state == SCAN};
  assign x_last = scan_x == CW'(GRID_N - 1);
  assign last_addr = x_last && scan_y == CW'(GRID_N - 1);
  cell_classifier u_cls (
    .cell_value(cell_value),
    .is_ship(is_ship),
    .is_hit(is_hit)
  );
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state <= IDLE;
      scan_x <= '0;
      scan_y <= '0;
      vld <= '0;
      acc_ship <= '0;
      acc_hit <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ship_count <= '0;
      hit_count <= '0;
      fleet_complete <= 1'b0;
      all_sunk <= 1'b0;
    end else begin
      vld <= tag[RD_LAT-2:0];
      done <= 1'b0;
      if (tag[RD_LAT-1]) begin
        acc_ship <= acc_ship + 7'(is_ship);
        acc_hit <= acc_hit + 7'(is_hit);
      end
      case (state)
        IDLE:
          if (start) begin
            state <= SCAN;
            busy <= 1'b1;
            acc_ship <= '0;
            acc_hit <= '0;
          end
        SCAN: begin
          scan_x <= x_last ? '0 : scan_x + 1'b1;
          if (x_last) scan_y <= last_addr ? '0 : scan_y + 1'b1;
          if (last_addr) state <= DRAIN;
        end
        // leave once the only tag still in flight is the one being accumulated at this edge
        DRAIN: if (tag[RD_LAT-2:0] == '0) state <= REPORT;
        REPORT: begin
          ship_count <= acc_ship;
          hit_count <= acc_hit;
          fleet_complete <= acc_ship + acc_hit == 7'(FLEET_CELLS);
          all_sunk <= acc_ship == '0 && acc_hit != '0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
